// File: rtl/cpu_pkg.sv
// Shared CPU definitions: PC width default, sequencer states, NOP encoding
// and the opcode constants that control decode keys on.
package cpu_pkg;

   localparam int PC_WIDTH_DEF = 32;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      HALT = 2'd2
   } pc_state_e;

   localparam logic [31:0] INST_NOP = 32'h0000_0000;

   localparam logic [5:0] OP_J   = 6'b000010;
   localparam logic [5:0] OP_BEQ = 6'b000100;

endpackage

// File: rtl/pc_next_sel.sv
// Next-PC selection for the PC stage: jump > branch > increment, plus a
// flag telling the sequencer that the chosen PC falls outside instruction memory.
import cpu_pkg::*;

module pc_next_sel #(
   parameter int PC_WIDTH   = PC_WIDTH_DEF,
   parameter int IMEM_DEPTH = 16
) (
   input  logic [PC_WIDTH-1:0] pc,
   input  logic                jump,
   input  logic [25:0]         jump_target,
   input  logic                branch_taken,
   input  logic [15:0]         branch_offset,
   output logic [PC_WIDTH-1:0] next_pc,
   output logic                out_of_range
);

   localparam logic [PC_WIDTH-1:0] DEPTH_W = PC_WIDTH'(IMEM_DEPTH);

   // Priority mux; branch offset is signed and relative to PC+1, wrapping mod 2^PC_WIDTH.
   always_comb begin
      next_pc = pc + PC_WIDTH'(1);
      if (jump) begin
         next_pc = PC_WIDTH'(jump_target);
      end else if (branch_taken) begin
         next_pc = pc + PC_WIDTH'(1) + PC_WIDTH'($signed(branch_offset));
      end
   end

   assign out_of_range = (next_pc >= DEPTH_W);

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter stage feeding instruction memory. IDLE/RUN/HALT sequencer,
// NOP-run halt, out-of-range fault and retired-instruction counter.
// Build option: define PC_RETIRE_CNT_EN to implement retired_count; otherwise
// it is tied to zero and no counter register exists.
//
// Handshake: there is no valid/ready pair on this stage. stall is a plain hold
// request sampled each rising edge; while stall is high in RUN nothing retires
// and PC, counters and state are all held. Every other cycle in RUN retires the
// instruction at current_addr_pc.
import cpu_pkg::*;

module pc_sequencer #(
   parameter int PC_WIDTH       = PC_WIDTH_DEF,
   parameter int RESET_PC       = 0,
   parameter int IMEM_DEPTH     = 16,
   parameter int NOP_HALT_COUNT = 3
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [31:0]         inst,
   input  logic                stall,
   input  logic                jump,
   input  logic [25:0]         jump_target,
   input  logic                branch_taken,
   input  logic [15:0]         branch_offset,
   output logic [PC_WIDTH-1:0] current_addr_pc,
   output logic                running,
   output logic                halted,
   output logic                fault,
   output logic [31:0]         retired_count
);

   localparam int NW = (NOP_HALT_COUNT < 1) ? 1 : $clog2(NOP_HALT_COUNT + 1);
   localparam logic [NW-1:0] NOP_LIMIT = NW'(NOP_HALT_COUNT);

   pc_state_e         state_q, state_d;
   logic [PC_WIDTH-1:0] pc_q, pc_d;
   logic [NW-1:0]     nop_q, nop_d, nop_inc;
   logic              fault_q, fault_d;
   logic [PC_WIDTH-1:0] next_pc;
   logic              out_of_range;
   logic              is_nop;

   pc_next_sel #(
      .PC_WIDTH   (PC_WIDTH),
      .IMEM_DEPTH (IMEM_DEPTH)
   ) u_next_sel (
      .pc            (pc_q),
      .jump          (jump),
      .jump_target   (jump_target),
      .branch_taken  (branch_taken),
      .branch_offset (branch_offset),
      .next_pc       (next_pc),
      .out_of_range  (out_of_range)
   );

   assign is_nop  = (inst == INST_NOP);
   assign nop_inc = nop_q + NW'(1);

   // State, PC, NOP run length and sticky fault.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         pc_q    <= PC_WIDTH'(RESET_PC);
         nop_q   <= '0;
         fault_q <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         nop_q   <= nop_d;
         fault_q <= fault_d;
      end
   end

   // Sequencer: the NOP-run halt wins over the range fault in the same cycle,
   // and a halting instruction leaves the PC on its own address.
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      nop_d   = nop_q;
      fault_d = fault_q;
      unique case (state_q)
         IDLE: state_d = RUN;
         RUN: begin
            if (!stall) begin
               nop_d = is_nop ? nop_inc : '0;
               if (is_nop && (nop_inc == NOP_LIMIT)) begin
                  state_d = HALT;
               end else if (out_of_range) begin
                  state_d = HALT;
                  fault_d = 1'b1;
               end else begin
                  pc_d = next_pc;
               end
            end
         end
         HALT: state_d = HALT;
         default: state_d = IDLE;
      endcase
   end

`ifdef PC_RETIRE_CNT_EN
   logic [31:0] retired_q;

   // One count per non-stalled RUN cycle, including the instruction that halts.
   always_ff @(posedge clk) begin
      if (rst) begin
         retired_q <= 32'd0;
      end else if ((state_q == RUN) && !stall) begin
         retired_q <= retired_q + 32'd1;
      end
   end

   assign retired_count = retired_q;
`else
   assign retired_count = 32'd0;
`endif

   assign current_addr_pc = pc_q;
   assign running         = (state_q == RUN);
   assign halted          = (state_q == HALT);
   assign fault           = fault_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed program scenarios plus randomized episodes,
// checked by a scoreboard fed from a behavioural reference model.
module tb_pc_sequencer;

   localparam int DEPTH = 16;
   localparam int NHC   = 3;
   localparam int EW    = 67;
   localparam int M_IDLE = 0;
   localparam int M_RUN  = 1;
   localparam int M_HALT = 2;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] inst = 32'd0;
   logic        stall = 1'b0;
   logic        jump = 1'b0;
   logic [25:0] jump_target = 26'd0;
   logic        branch_taken = 1'b0;
   logic [15:0] branch_offset = 16'd0;
   logic [31:0] current_addr_pc;
   logic        running, halted, fault;
   logic [31:0] retired_count;

   logic [EW-1:0] exp_q[$];
   int n_vec  = 0;
   int n_miss = 0;

   // Reference model state
   logic [31:0] imem [DEPTH];
   logic [31:0] mpc   = 32'd0;
   int          m_mode = M_IDLE;
   logic        mfault = 1'b0;
   logic [31:0] mret  = 32'd0;
   int          mnop  = 0;

   pc_sequencer #(
      .PC_WIDTH       (32),
      .RESET_PC       (0),
      .IMEM_DEPTH     (DEPTH),
      .NOP_HALT_COUNT (NHC)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .inst            (inst),
      .stall           (stall),
      .jump            (jump),
      .jump_target     (jump_target),
      .branch_taken    (branch_taken),
      .branch_offset   (branch_offset),
      .current_addr_pc (current_addr_pc),
      .running         (running),
      .halted          (halted),
      .fault           (fault),
      .retired_count   (retired_count)
   );

   // Clock
   always #5 clk = ~clk;

   // Drive one cycle of inputs, advance the model, queue the expected outputs.
   task automatic step(input logic r, input logic st, input logic j,
                       input logic [25:0] jt, input logic bt, input logic [15:0] bo);
      logic [31:0] cur;
      logic [31:0] nxt;
      logic [31:0] er;
      @(negedge clk);
      cur = imem[mpc[3:0]];
      rst = r; stall = st; jump = j; jump_target = jt;
      branch_taken = bt; branch_offset = bo; inst = cur;
      if (r) begin
         mpc = 32'd0; m_mode = M_IDLE; mfault = 1'b0; mret = 32'd0; mnop = 0;
      end else if (m_mode == M_IDLE) begin
         m_mode = M_RUN;
      end else if (m_mode == M_RUN && !st) begin
         mret = mret + 32'd1;
         mnop = (cur == 32'd0) ? mnop + 1 : 0;
         if (j)       nxt = {6'd0, jt};
         else if (bt) nxt = mpc + 32'd1 + {{16{bo[15]}}, bo};
         else         nxt = mpc + 32'd1;
         if (cur == 32'd0 && mnop == NHC) begin
            m_mode = M_HALT;
         end else if (nxt >= DEPTH) begin
            m_mode = M_HALT; mfault = 1'b1;
         end else begin
            mpc = nxt;
         end
      end
`ifdef PC_RETIRE_CNT_EN
      er = mret;
`else
      er = 32'd0;
`endif
      exp_q.push_back({mpc, (m_mode == M_RUN), (m_mode == M_HALT), mfault, er});
   endtask

   task automatic plain(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 26'd0, 1'b0, 16'd0);
   endtask

   task automatic do_reset(input int n);
      for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 26'd0, 1'b0, 16'd0);
   endtask

   // Advance with plain increments until the model PC reaches target (bounded).
   task automatic run_to(input logic [31:0] target);
      for (int i = 0; i < 40 && !(mpc == target && m_mode == M_RUN); i++) plain(1);
   endtask

   task automatic fill_linear();
      for (int i = 0; i < DEPTH; i++) imem[i] = 32'h2000_0000 + 32'(i) + 32'd1;
   endtask

   // Scoreboard monitor: compare DUT outputs one time unit after each rising edge.
   initial begin
      logic [EW-1:0] e;
      logic [EW-1:0] got;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            got = {current_addr_pc, running, halted, fault, retired_count};
            n_vec++;
            if (got !== e) begin
               n_miss++;
               $display("FAIL sb t=%0t got pc=%0d run=%b halt=%b fault=%b ret=%0d required pc=%0d run=%b halt=%b fault=%b ret=%0d",
                        $time, got[66:35], got[34], got[33], got[32], got[31:0],
                        e[66:35], e[34], e[33], e[32], e[31:0]);
            end
         end
      end
   end

   // Stimulus
   initial begin
      fill_linear();

      // Reset hold, one IDLE cycle, then RUN
      do_reset(2);
      plain(2);

      // Program: linear to 10, jump to 12 at 10, NOPs at 13..15 -> NOP halt at 15
      fill_linear();
      imem[13] = 32'd0; imem[14] = 32'd0; imem[15] = 32'd0;
      do_reset(2);
      run_to(32'd10);
      step(1'b0, 1'b0, 1'b1, 26'd12, 1'b0, 16'd0);
      plain(6);

      // Stall at PC 5 for 3 cycles, then release
      fill_linear();
      do_reset(1);
      run_to(32'd5);
      for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 26'd0, 1'b0, 16'd0);
      plain(2);

      // Backward branch from 4 to 2, then jump beats branch to 9
      do_reset(1);
      run_to(32'd4);
      step(1'b0, 1'b0, 1'b0, 26'd0, 1'b1, 16'hFFFD);
      step(1'b0, 1'b0, 1'b1, 26'd9, 1'b1, 16'd3);
      plain(2);

      // Fall off the end at 15 -> fault; junk ignored in HALT; reset clears fault
      do_reset(1);
      run_to(32'd15);
      plain(1);
      for (int i = 0; i < 5; i++)
         step(1'b0, 1'($urandom_range(0, 1)), 1'b1, 26'($urandom_range(0, 15)), 1'b1, 16'd1);
      do_reset(1);
      plain(2);

      // Reset while running at PC 7
      do_reset(1);
      run_to(32'd7);
      do_reset(1);
      plain(2);

      // Randomized episodes
      for (int ep = 0; ep < 25; ep++) begin
         for (int i = 0; i < DEPTH; i++)
            imem[i] = ($urandom_range(0, 2) == 0) ? 32'd0 : ($urandom | 32'd1);
         do_reset(1 + $urandom_range(0, 1));
         for (int c = 0; c < 40; c++) begin
            step(1'($urandom_range(0, 59) == 0),
                 1'($urandom_range(0, 3) == 0),
                 1'($urandom_range(0, 7) == 0),
                 26'($urandom_range(0, 17)),
                 1'($urandom_range(0, 5) == 0),
                 16'($urandom_range(0, 16) - 8));
         end
      end

      @(negedge clk);
      @(negedge clk);
      if (exp_q.size() != 0) begin
         n_vec++;
         n_miss++;
         $display("FAIL drain pending=%0d required=0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Program-counter stage directly upstream of the instruction memory in the single-cycle CPU.
- Holds the word-indexed PC and drives current_addr_pc into instruction memory each cycle.
- Selects the next PC from increment, jump or branch.
- Runs a small IDLE/RUN/HALT state machine: halt on a run of NOPs or an out-of-range fetch.
- Counts retired instructions.

Parameters:
PC_WIDTH, 32, width of PC and of current_addr_pc
RESET_PC, 0, word index loaded on reset
IMEM_DEPTH, 16, number of instruction-memory words; legal PC range is 0..IMEM_DEPTH-1
NOP_HALT_COUNT, 3, consecutive all-zero instructions that trigger HALT (must be >= 1)

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  synchronous, active-high reset
inst  input  32  instruction currently fetched at current_addr_pc
stall  input  1  hold PC this cycle; no retire
jump  input  1  current instruction is a taken jump
jump_target  input  26  word index of jump destination (word-addressed, no shift)
branch_taken  input  1  current instruction is a taken branch
branch_offset  input  16  signed word offset relative to PC+1
current_addr_pc  output  PC_WIDTH  PC presented to instruction memory
running  output  1  state == RUN
halted  output  1  state == HALT
fault  output  1  sticky: HALT entered because the next PC was out of range
retired_count  output  32  instructions retired since reset

Behaviour:
Reset values:
- rst is sampled on the rising clk edge and overrides every other input.
- After reset: state=IDLE, current_addr_pc=RESET_PC, running=0, halted=0, fault=0, retired_count=0, NOP counter=0.
- Reset asserted mid-run or in HALT gives the same result one edge later.

State machine:
- IDLE: lasts exactly one cycle after rst deasserts; the PC is held so instruction memory settles; stall is ignored; goes to RUN.
- RUN: on each non-stalled cycle the instruction at current_addr_pc retires:
  - retired_count increments and wraps mod 2^32.
  - The next PC is chosen by priority jump > branch > increment.
  - Jump: zero-extend jump_target.
  - Branch: PC+1+sign-extend(branch_offset), mod 2^PC_WIDTH.
  - Increment: PC+1.
- RUN with stall=1: PC, counters and state are all held.
- HALT: PC, retired_count and fault are frozen. It exits only via rst; all other inputs are ignored.

NOP rule:
- inst==0 on a retiring cycle increments the NOP counter; any other retired instruction clears it.
- When the retiring instruction would make the counter equal NOP_HALT_COUNT:
  - go to HALT, that instruction still counts as retired;
  - the PC does not advance and stays at the last NOP's address; fault=0.
- The NOP rule takes precedence over the range check in the same cycle.

Range rule:
- If the selected next PC is >= IMEM_DEPTH, go to HALT with fault=1.
- The PC holds the faulting instruction's address; that instruction counts as retired.

Other:
- jump and branch_taken asserted together: jump wins, branch ignored.
- Latency: a next-PC decision made in cycle N appears on current_addr_pc in cycle N+1.

Optional Feature:
PC_RETIRE_CNT_EN:
- Defined: retired_count is implemented as specified above.
- Undefined: no counter register; retired_count is tied to 32'd0; all other behaviour is unchanged.

Decomposition:
Shared package cpu_pkg holds:
- the PC_WIDTH default;
- the state enum IDLE/RUN/HALT;
- the NOP encoding 32'h0;
- opcode constants J=6'b000010 and BEQ=6'b000100 used by control.

One combinational sub-module, pc_next_sel:
- inputs: pc, jump, jump_target, branch_taken, branch_offset;
- outputs: next_pc and an out_of_range flag.
The FSM, NOP counter and retire counter stay in pc_sequencer.

Test Plan:
1. rst high 2 cycles then low -> current_addr_pc=0, running=0 for one cycle, then running=1; retired_count=0.
2. Reset-loaded test program: increments 0..10, jump to 12 at index 10, NOPs at 13..15 -> PC sequence 0..10,12,13,14,15; halted=1 with PC=15, fault=0, retired_count=15.
3. Run to PC=5, stall=1 for 3 cycles -> PC stays 5 and retired_count is unchanged; releases to 6 after stall drops.
4. At PC=4, branch_taken=1, branch_offset=-3 -> next PC=2; at PC=2, jump=1 with branch_taken=1 and jump_target=9 -> next PC=9.
5. At PC=15 with a non-NOP and no jump -> halted=1, fault=1, PC stays 15; later stimulus is ignored until rst, which then clears fault.
6. rst asserted while running at PC=7 -> next edge PC=0, state=IDLE, retired_count=0; with PC_RETIRE_CNT_EN undefined, retired_count stays 0 throughout scenario 2.
